// File: rtl/imul_pkg.sv
// imul_pkg: shared types and constants for the iterative multiplier.
// State encoding for the control FSM and the default operand width.
package imul_pkg;

    localparam int IMUL_NBITS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } imul_state_e;

endpackage

// File: rtl/imul_dpath.sv
// imul_dpath: shift-and-add datapath (a_reg, b_reg, accumulator).
// Optional IMUL_EARLY_EXIT_EN drives b_zero_o; otherwise it is tied low.
module imul_dpath
    import imul_pkg::*;
#(
    parameter int nbits = IMUL_NBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic             add_en_i,
    input  logic [nbits-1:0] a_i,
    input  logic [nbits-1:0] b_i,
    output logic             b_lsb_o,
    output logic             b_zero_o,
    output logic [nbits-1:0] prod_o
);

    logic [nbits-1:0] a_q, a_d;
    logic [nbits-1:0] b_q, b_d;
    logic [nbits-1:0] acc_q, acc_d;

    // Load operands, or step one shift-and-add iteration.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (load_i) begin
            a_d   = a_i;
            b_d   = b_i;
            acc_d = '0;
        end else if (shift_en_i) begin
            if (add_en_i) begin
                acc_d = acc_q + a_q;
            end
            a_d = a_q << 1;
            b_d = b_q >> 1;
        end
    end

    // Operand and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign b_lsb_o = b_q[0];
    assign prod_o  = acc_q;

    // High when the current iteration leaves no multiplier bits set.
`ifdef IMUL_EARLY_EXIT_EN
    assign b_zero_o = ((b_q >> 1) == '0);
`else
    assign b_zero_o = 1'b0;
`endif

endmodule

// File: rtl/imul_unit.sv
// imul_unit: iterative unsigned multiplier, low nbits of the product.
// Define IMUL_EARLY_EXIT_EN to finish once the multiplier is exhausted.
module imul_unit
    import imul_pkg::*;
#(
    parameter int nbits = IMUL_NBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [nbits-1:0] req_a,
    input  logic [nbits-1:0] req_b,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [nbits-1:0] resp_prod
);

    localparam int CW = (nbits > 1) ? $clog2(nbits) : 1;
    localparam logic [CW-1:0] LAST = CW'(nbits - 1);

    imul_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          load;
    logic          shift_en;
    logic          add_en;
    logic          b_lsb;
    logic          b_zero;

    // Next-state, iteration count and handshake outputs.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load     = 1'b0;
        shift_en = 1'b0;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                shift_en = 1'b1;
                if (count_q == LAST || b_zero) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and iteration counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign add_en = shift_en & b_lsb;

    imul_dpath #(
        .nbits(nbits)
    ) u_dpath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .shift_en_i(shift_en),
        .add_en_i  (add_en),
        .a_i       (req_a),
        .b_i       (req_b),
        .b_lsb_o   (b_lsb),
        .b_zero_o  (b_zero),
        .prod_o    (resp_prod)
    );

endmodule

// File: tb/tb_imul_unit.sv
// tb_imul_unit: directed self-checking bench for imul_unit (nbits=32).
// Expected latencies follow IMUL_EARLY_EXIT_EN when it is defined.
module tb_imul_unit;

`ifdef IMUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    localparam int FULL = 33;

    logic        clk;
    logic        rst_n;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_prod;

    int n_chk;
    int n_fail;

    imul_unit #(
        .nbits(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_a    (req_a),
        .req_b    (req_b),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_prod(resp_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a request now; return #1 after the accepting edge.
    task automatic issue(input string tag, input logic [31:0] a,
                         input logic [31:0] b);
        chk({tag, "_rdy"}, {31'd0, req_rdy}, 32'd1);
        req_val = 1'b1;
        req_a   = a;
        req_b   = b;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        req_a   = ~a;
        req_b   = ~b;
    endtask

    // Count cycles from accept until resp_val, then check the product.
    task automatic wait_resp(input string tag, input logic [31:0] exp,
                             input int lat_full, input int lat_ee);
        int n;
        n = 1;
        while (resp_val !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, EE ? lat_ee : lat_full);
        chk({tag, "_prod"}, resp_prod, exp);
    endtask

    // With resp_rdy high, the next edge must return to IDLE.
    task automatic retire(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_idle_rdy"}, {31'd0, req_rdy}, 32'd1);
        chk({tag, "_idle_val"}, {31'd0, resp_val}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input int lat_ee);
        issue(tag, a, b);
        wait_resp(tag, exp, FULL, lat_ee);
        retire(tag);
    endtask

    logic [31:0] va[3];
    logic [31:0] vb[3];
    logic [31:0] vp[3];

    initial begin
        int cyc;
        int acc_idx;
        int rsp_idx;
        int last_hs;
        logic fire;
        logic hs;

        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req_val  = 1'b0;
        req_a    = 32'h0;
        req_b    = 32'h0;
        resp_rdy = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("rst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("rst_resp_prod", resp_prod, 32'd0);
        rst_n = 1'b1;

        run("m3x5", 32'd3, 32'd5, 32'd15, 4);
        run("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33);
        run("m8x2", 32'h8000_0000, 32'd2, 32'h0, 3);
        run("mx0", 32'h1234_5678, 32'd0, 32'h0, 2);
        run("m1234x10", 32'h1234, 32'h10, 32'h1_2340, 6);
        run("mneg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 4);

        resp_rdy = 1'b0;
        issue("bp", 32'h11, 32'h11);
        wait_resp("bp", 32'h121, FULL, 6);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_val", {31'd0, resp_val}, 32'd1);
            chk("bp_hold_prod", resp_prod, 32'h121);
            chk("bp_hold_rdy", {31'd0, req_rdy}, 32'd0);
        end
        resp_rdy = 1'b1;
        retire("bp");

        issue("rstcalc", 32'h55, 32'h77);
        repeat (4) @(posedge clk);
        #1;
        chk("rstcalc_busy", {31'd0, req_rdy}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstcalc_async_rdy", {31'd0, req_rdy}, 32'd1);
        chk("rstcalc_async_prod", resp_prod, 32'd0);
        @(posedge clk);
        #1;
        chk("rstcalc_rdy", {31'd0, req_rdy}, 32'd1);
        chk("rstcalc_val", {31'd0, resp_val}, 32'd0);
        rst_n = 1'b1;
        run("m7x6", 32'd7, 32'd6, 32'd42, 4);

        va = '{32'd9, 32'hFFFF, 32'd5};
        vb = '{32'd9, 32'hFFFF, 32'd0};
        vp = '{32'd81, 32'hFFFE_0001, 32'd0};
        cyc     = 0;
        acc_idx = 0;
        rsp_idx = 0;
        last_hs = -1;
        req_val = 1'b1;
        req_a   = va[0];
        req_b   = vb[0];
        while (rsp_idx < 3 && cyc < 400) begin
            @(negedge clk);
            fire = req_val && req_rdy;
            hs   = resp_val && resp_rdy;
            if (hs) begin
                chk("b2b_prod", resp_prod, vp[rsp_idx]);
                rsp_idx++;
                last_hs = cyc;
            end
            if (fire) begin
                if (last_hs >= 0) begin
                    chk("b2b_gap", cyc - last_hs, 32'd1);
                end
                acc_idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (fire) begin
                if (acc_idx < 3) begin
                    req_a = va[acc_idx];
                    req_b = vb[acc_idx];
                end else begin
                    req_val = 1'b0;
                end
            end
        end
        chk("b2b_resps", rsp_idx, 32'd3);
        chk("b2b_accepts", acc_idx, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
